cx_issue_buffer: RTL and testbench

- Upstream front-end for the combinational custom-instruction (CX) execution unit.
- Accepts issue requests from the core over a valid/ready handshake and registers the operands into an operand stage that drives the CX unit.
- Captures the unit's result, error and invalid-opcode flags, tagged with the request ID, into a response FIFO.
- Returns responses to the core over a second valid/ready handshake, decoupling core backpressure from the CX datapath.

---
 rtl/cx_pkg.sv | 16 +
 rtl/cx_rsp_fifo.sv | 69 ++++++
 rtl/cx_issue_buffer.sv | 139 +++++++++++++
 tb/tb_cx_issue_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cx_pkg.sv
// Shared widths, opcode constants and helpers for the CX issue front-end.
package cx_pkg;

    localparam int CX_OPCODE_W = 10;
    localparam int CX_DATA_W   = 32;

    localparam logic [CX_OPCODE_W-1:0] CX_OP_U2L  = 10'h003;
    localparam logic [CX_OPCODE_W-1:0] CX_OP_L2U  = 10'h004;
    localparam logic [CX_OPCODE_W-1:0] CX_OP_MS1B = 10'h008;

    // Packed width of a response {id, result, error, invalid} for a given tag width.
    function automatic int cx_rsp_width(input int id_w);
        return id_w + CX_DATA_W + 2;
    endfunction

endpackage

// File: rtl/cx_rsp_fifo.sv
// Synchronous response FIFO; the head is read straight from storage, so data is
// only visible after the edge that wrote it (no fall-through).
module cx_rsp_fifo
    import cx_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_push,
    input  logic [cx_rsp_width(ID_W)-1:0]  i_push_data,
    input  logic                           i_pop,
    output logic [cx_rsp_width(ID_W)-1:0]  o_head_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH):0]         o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [CX_DATA_W-1:0] result;
        logic                 error;
        logic                 invalid;
    } cx_rsp_t;

    cx_rsp_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_push;
    logic               w_pop;

    assign o_full      = (r_level == LVL_W'(DEPTH));
    assign o_empty     = (r_level == '0);
    assign o_level     = r_level;
    assign o_head_data = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/cx_issue_buffer.sv
// Issue front-end for the combinational CX unit: operand stage feeding the unit,
// tagged response FIFO back to the core, and saturating error/invalid counters.
module cx_issue_buffer
    import cx_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CX_OPCODE_W-1:0]  req_opcode,
    input  logic [CX_DATA_W-1:0]    req_op_a,
    input  logic [CX_DATA_W-1:0]    req_op_b,
    input  logic [ID_W-1:0]         req_id,
    output logic [CX_OPCODE_W-1:0]  cx_opcode,
    output logic [CX_DATA_W-1:0]    cx_op_a,
    output logic [CX_DATA_W-1:0]    cx_op_b,
    input  logic                    cx_invalid_opcode,
    input  logic [CX_DATA_W-1:0]    cx_result,
    input  logic                    cx_result_valid,
    input  logic                    cx_result_error,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [CX_DATA_W-1:0]    rsp_result,
    output logic                    rsp_error,
    output logic                    rsp_invalid,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        inv_cnt
);

    localparam int RSP_W = cx_rsp_width(ID_W);

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [CX_DATA_W-1:0] result;
        logic                 error;
        logic                 invalid;
    } cx_rsp_t;

    logic                   r_op_vld;
    logic [CX_OPCODE_W-1:0] r_opcode;
    logic [CX_DATA_W-1:0]   r_op_a;
    logic [CX_DATA_W-1:0]   r_op_b;
    logic [ID_W-1:0]        r_id;
    logic [CNT_W-1:0]       r_err_cnt;
    logic [CNT_W-1:0]       r_inv_cnt;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_accept;
    cx_rsp_t                w_push_rsp;
    cx_rsp_t                w_head_rsp;
    logic [RSP_W-1:0]       w_head_bits;

    // Both ports are valid/ready: a transfer happens on an edge where valid and
    // ready are both high. req_ready never looks at rsp_ready, so core response
    // backpressure reaches the issue side only through a full FIFO.
    assign w_push    = r_op_vld && cx_result_valid && !w_full;
    assign req_ready = !r_op_vld || w_push;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = !w_empty;
    assign w_pop     = rsp_valid && rsp_ready;

    assign cx_opcode = r_opcode;
    assign cx_op_a   = r_op_a;
    assign cx_op_b   = r_op_b;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op_vld <= 1'b0;
            r_opcode <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_id     <= '0;
        end else if (w_accept) begin
            r_op_vld <= 1'b1;
            r_opcode <= req_opcode;
            r_op_a   <= req_op_a;
            r_op_b   <= req_op_b;
            r_id     <= req_id;
        end else if (w_push) begin
            r_op_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_cnt <= '0;
            r_inv_cnt <= '0;
        end else if (w_push) begin
            if (cx_result_error && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (cx_invalid_opcode && (r_inv_cnt != {CNT_W{1'b1}})) begin
                r_inv_cnt <= r_inv_cnt + 1'b1;
            end
        end
    end

    assign err_cnt = r_err_cnt;
    assign inv_cnt = r_inv_cnt;

    always_comb begin
        w_push_rsp         = '0;
        w_push_rsp.id      = r_id;
        w_push_rsp.result  = cx_result;
        w_push_rsp.error   = cx_result_error;
        w_push_rsp.invalid = cx_invalid_opcode;
    end

    cx_rsp_fifo #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_push),
        .i_push_data (w_push_rsp),
        .i_pop       (w_pop),
        .o_head_data (w_head_bits),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (level)
    );

    assign w_head_rsp  = w_head_bits;
    assign rsp_id      = w_head_rsp.id;
    assign rsp_result  = w_head_rsp.result;
    assign rsp_error   = w_head_rsp.error;
    assign rsp_invalid = w_head_rsp.invalid;

endmodule

// File: tb/tb_cx_issue_buffer.sv
// Directed bench for cx_issue_buffer with a small behavioural CX unit attached.
module tb_cx_issue_buffer;

    localparam int ID_W  = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [9:0]        req_opcode;
    logic [31:0]       req_op_a;
    logic [31:0]       req_op_b;
    logic [ID_W-1:0]   req_id;
    logic [9:0]        cx_opcode;
    logic [31:0]       cx_op_a;
    logic [31:0]       cx_op_b;
    logic              cx_invalid_opcode;
    logic [31:0]       cx_result;
    logic              cx_result_valid;
    logic              cx_result_error;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_error;
    logic              rsp_invalid;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  inv_cnt;

    logic              cx_vld_en;
    int                checks;
    int                errors;
    logic [ID_W-1:0]   exp_q[$];

    cx_issue_buffer #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_opcode        (req_opcode),
        .req_op_a          (req_op_a),
        .req_op_b          (req_op_b),
        .req_id            (req_id),
        .cx_opcode         (cx_opcode),
        .cx_op_a           (cx_op_a),
        .cx_op_b           (cx_op_b),
        .cx_invalid_opcode (cx_invalid_opcode),
        .cx_result         (cx_result),
        .cx_result_valid   (cx_result_valid),
        .cx_result_error   (cx_result_error),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_result        (rsp_result),
        .rsp_error         (rsp_error),
        .rsp_invalid       (rsp_invalid),
        .level             (level),
        .err_cnt           (err_cnt),
        .inv_cnt           (inv_cnt)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural CX unit: U2L, L2U, MS1B; anything else is an invalid opcode.
    always_comb begin
        cx_result         = '0;
        cx_result_error   = 1'b0;
        cx_invalid_opcode = 1'b0;
        cx_result_valid   = cx_vld_en;
        case (cx_opcode)
            10'h003: begin
                for (int b = 0; b < 4; b++) begin
                    cx_result[b*8 +: 8] = cx_op_a[b*8 +: 8];
                    if (cx_op_a[b*8 +: 8] >= 8'h41 && cx_op_a[b*8 +: 8] <= 8'h5A)
                        cx_result[b*8 +: 8] = cx_op_a[b*8 +: 8] + 8'h20;
                end
            end
            10'h004: begin
                for (int b = 0; b < 4; b++) begin
                    cx_result[b*8 +: 8] = cx_op_a[b*8 +: 8];
                    if (cx_op_a[b*8 +: 8] >= 8'h61 && cx_op_a[b*8 +: 8] <= 8'h7A)
                        cx_result[b*8 +: 8] = cx_op_a[b*8 +: 8] - 8'h20;
                end
            end
            10'h008: begin
                if (cx_op_a == 32'd0) begin
                    cx_result_error = 1'b1;
                end else begin
                    for (int b = 0; b < 32; b++) begin
                        if (cx_op_a[b]) cx_result = 32'(b);
                    end
                end
            end
            default: cx_invalid_opcode = 1'b1;
        endcase
    end

    // Driver: present a request until it is accepted; returns 1ns after the accepting edge.
    task automatic issue(input logic [9:0] opc, input logic [31:0] a, input logic [ID_W-1:0] id);
        logic acc;
        int   n;
        req_valid  = 1'b1;
        req_opcode = opc;
        req_op_a   = a;
        req_op_b   = 32'h0000_1234;
        req_id     = id;
        acc        = 1'b0;
        n          = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout id=%0d: req_ready never rose", id);
        end
    endtask

    // Driver: wait for a response with rsp_ready high and capture it as it pops.
    task automatic get_rsp(output logic [ID_W-1:0] id, output logic [31:0] res,
                           output logic err, output logic inv);
        logic got;
        int   n;
        rsp_ready = 1'b1;
        got = 1'b0;
        n   = 0;
        id = '0; res = '0; err = 1'b0; inv = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                id  = rsp_id;
                res = rsp_result;
                err = rsp_error;
                inv = rsp_invalid;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid never rose");
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (err_cnt !== 16'd0 || inv_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", err_cnt, inv_cnt); end
        checks++; if (cx_opcode !== 10'd0 || cx_op_a !== 32'd0 || cx_op_b !== 32'd0) begin errors++; $display("FAIL reset_cx got=%h/%h/%h exp=0", cx_opcode, cx_op_a, cx_op_b); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_single();
        logic [ID_W-1:0] id; logic [31:0] res; logic err; logic inv;
        rsp_ready = 1'b0;
        issue(10'h003, 32'h41424344, 4'd5);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got=%b exp=0", rsp_valid); end
        checks++; if (cx_opcode !== 10'h003 || cx_op_a !== 32'h41424344) begin errors++; $display("FAIL single_cx got=%h/%h exp=003/41424344", cx_opcode, cx_op_a); end
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL single_latency got valid=%b level=%0d exp valid=1 level=1", rsp_valid, level); end
        get_rsp(id, res, err, inv);
        checks++; if (id !== 4'd5) begin errors++; $display("FAIL single_id got=%0d exp=5", id); end
        checks++; if (res !== 32'h61626364) begin errors++; $display("FAIL single_result got=%h exp=61626364", res); end
        checks++; if (err !== 1'b0 || inv !== 1'b0) begin errors++; $display("FAIL single_flags got=%b%b exp=00", err, inv); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_after got=%0d exp=0", level); end
    endtask

    task automatic test_ms1b();
        logic [ID_W-1:0] id; logic [31:0] res; logic err; logic inv;
        rsp_ready = 1'b0;
        issue(10'h008, 32'h00008000, 4'd1);
        issue(10'h008, 32'h00000000, 4'd2);
        get_rsp(id, res, err, inv);
        checks++; if (id !== 4'd1 || res !== 32'd15 || err !== 1'b0) begin errors++; $display("FAIL ms1b_first got id=%0d res=%0d err=%b exp id=1 res=15 err=0", id, res, err); end
        get_rsp(id, res, err, inv);
        checks++; if (id !== 4'd2 || res !== 32'd0 || err !== 1'b1) begin errors++; $display("FAIL ms1b_zero got id=%0d res=%0d err=%b exp id=2 res=0 err=1", id, res, err); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL ms1b_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (inv_cnt !== 16'd0) begin errors++; $display("FAIL ms1b_inv_cnt got=%0d exp=0", inv_cnt); end
    endtask

    task automatic test_invalid();
        logic [ID_W-1:0] id; logic [31:0] res; logic err; logic inv;
        rsp_ready = 1'b0;
        issue(10'h3FF, 32'hDEADBEEF, 4'd3);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL invalid_no_stall got req_ready=%b exp=1", req_ready); end
        get_rsp(id, res, err, inv);
        checks++; if (id !== 4'd3 || inv !== 1'b1 || res !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL invalid_rsp got id=%0d inv=%b res=%h err=%b exp id=3 inv=1 res=0 err=0", id, inv, res, err); end
        checks++; if (inv_cnt !== 16'd1 || err_cnt !== 16'd1) begin errors++; $display("FAIL invalid_cnt got inv=%0d err=%0d exp inv=1 err=1", inv_cnt, err_cnt); end
    endtask

    task automatic test_stall();
        logic [ID_W-1:0] id; logic [31:0] res; logic err; logic inv;
        rsp_ready = 1'b0;
        cx_vld_en = 1'b0;
        issue(10'h004, 32'h00000061, 4'd4);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (level !== 3'd0 || req_ready !== 1'b0) begin errors++; $display("FAIL stall_hold got level=%0d req_ready=%b exp level=0 req_ready=0", level, req_ready); end
        cx_vld_en = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL stall_release got level=%0d exp=1", level); end
        get_rsp(id, res, err, inv);
        checks++; if (id !== 4'd4 || res !== 32'h00000041) begin errors++; $display("FAIL stall_rsp got id=%0d res=%h exp id=4 res=00000041", id, res); end
    endtask

    task automatic test_back_to_back();
        logic [ID_W-1:0] id; logic [31:0] res; logic err; logic inv;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            issue(10'h004, 32'h61626300 + 32'(k), ID_W'(k));
            exp_q.push_back(ID_W'(k));
        end
        req_valid  = 1'b1;
        req_opcode = 10'h004;
        req_op_a   = 32'h61626305;
        req_id     = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_full_level got=%0d exp=4", level); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_req_ready got=%b exp=0", req_ready); end
        checks++; if (cx_op_a !== 32'h61626304) begin errors++; $display("FAIL b2b_held_operand got=%h exp=61626304", cx_op_a); end
        exp_q.push_back(4'd5);
        fork
            issue(10'h004, 32'h61626305, 4'd5);
            begin
                for (int k = 0; k < 6; k++) begin
                    logic [ID_W-1:0] e;
                    get_rsp(id, res, err, inv);
                    e = exp_q.pop_front();
                    checks++;
                    if (id !== e || res !== (32'h41424300 + 32'(e))) begin
                        errors++;
                        $display("FAIL b2b_order k=%0d got id=%0d res=%h exp id=%0d res=%h", k, id, res, e, 32'h41424300 + 32'(e));
                    end
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;
        checks++; if (level !== 3'd0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got level=%0d valid=%b exp 0/0 (no duplicate)", level, rsp_valid); end
    endtask

    task automatic test_full_pulse();
        rsp_ready = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            issue(10'h003, 32'(k), ID_W'(k));
        end
        checks++; if (level !== 3'd4 || req_ready !== 1'b0) begin errors++; $display("FAIL full_start got level=%0d req_ready=%b exp 4/0", level, req_ready); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_no_push got level=%0d exp=3", level); end
        checks++; if (rsp_id !== 4'd7) begin errors++; $display("FAIL full_new_head got id=%0d exp=7", rsp_id); end
        @(posedge clk);
        #1;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_push_next got level=%0d exp=4", level); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_three_left got level=%0d exp=3", level); end
    endtask

    task automatic test_async_reset();
        logic [ID_W-1:0] id; logic [31:0] res; logic err; logic inv;
        req_valid  = 1'b1;
        req_opcode = 10'h003;
        req_op_a   = 32'h00000011;
        req_id     = 4'd11;
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL areset_fifo got valid=%b level=%0d exp 0/0", rsp_valid, level); end
        checks++; if (err_cnt !== 16'd0 || inv_cnt !== 16'd0) begin errors++; $display("FAIL areset_cnt got=%0d/%0d exp=0/0", err_cnt, inv_cnt); end
        checks++; if (cx_opcode !== 10'd0 || cx_op_a !== 32'd0 || cx_op_b !== 32'd0) begin errors++; $display("FAIL areset_cx got=%h/%h/%h exp=0", cx_opcode, cx_op_a, cx_op_b); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_discard got valid=%b exp=0", rsp_valid); end
        issue(10'h003, 32'h5A5A5A5A, 4'd9);
        get_rsp(id, res, err, inv);
        checks++; if (id !== 4'd9 || res !== 32'h7A7A7A7A || err !== 1'b0 || inv !== 1'b0) begin errors++; $display("FAIL areset_after got id=%0d res=%h exp id=9 res=7a7a7a7a", id, res); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL areset_level_after got=%0d exp=0", level); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_op_a   = '0;
        req_op_b   = '0;
        req_id     = '0;
        rsp_ready  = 1'b0;
        cx_vld_en  = 1'b1;
        test_reset();
        test_single();
        test_ms1b();
        test_invalid();
        test_stall();
        test_back_to_back();
        test_full_pulse();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
